font_flash_reader: RTL
======================

Name: font_flash_reader

Overview:
- Consumer end of the font address calculation unit: accepts the 30-bit bit-address offset (font + x + y), adds the character offset once the character value is known, and fetches the containing word from font flash.
- Returns the single glyph pixel bit to the ALU pipe over a valid/ready handshake.
- Sits between pipe_3_alu address calculation and the flash read port.

Parameters:
- memFontHeight, 128, glyph height in flash (pixels), power of 2
- memFontWidth, 64, glyph width in flash (pixels), power of 2
- charactersPerFont, 256, glyphs per font, power of 2
- FLASH_WORD_W, 32, flash read data width (bits), power of 2, 8..64
- TIMEOUT_CYCLES, 255, max cycles waiting for flash_rd_valid, 1..255

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- addressOffsetBits  in  30  bit offset from address calculation (no character term)
- characterIndex  in  16  character value read from RAM; low log2(charactersPerFont) bits used
- flash_rd_req  out  1  flash read strobe, level, held until accepted
- flash_rd_addr  out  30-log2(FLASH_WORD_W)  word address
- flash_rd_valid  in  1  read data valid, single-cycle pulse
- flash_rd_data  in  FLASH_WORD_W  read word
- pix_valid  out  1  pixel result valid
- pix_ready  in  1  downstream accepts pixel
- pix  out  1  glyph pixel bit
- pix_err  out  1  result produced by timeout, pixel forced 0

Behaviour:
- Reset values (asynchronous, while rst=0): state IDLE, req_ready=0, flash_rd_req=0, flash_rd_addr=0, pix_valid=0, pix=0, pix_err=0, timeout counter 0, cache invalid.
- Reset asserted mid-operation aborts the transaction with no output. A flash_rd_valid arriving after reset is ignored.
- Address: bitAddr = (addressOffsetBits + (characterIndex[log2(charactersPerFont)-1:0] << (log2(memFontHeight)+log2(memFontWidth)))) mod 2^30.
  - wordAddr = bitAddr >> log2(FLASH_WORD_W).
  - bitSel = bitAddr[log2(FLASH_WORD_W)-1:0].
  - Overflow wraps silently.
- Pixel = flash_rd_data[bitSel], LSB = lowest bit address.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, register bitSel and wordAddr, then go to ISSUE.
  - ISSUE: flash_rd_req=1, flash_rd_addr=wordAddr, go to WAIT. The address is registered one cycle after acceptance.
  - WAIT: flash_rd_req stays 1 and the counter increments each cycle.
    - flash_rd_valid → capture pix, pix_err=0, flash_rd_req=0, go to RESP.
    - Counter reaches TIMEOUT_CYCLES without valid → pix=0, pix_err=1, flash_rd_req=0, go to RESP.
    - flash_rd_valid and the timeout in the same cycle → data wins, pix_err=0.
  - RESP: pix_valid=1. pix and pix_err are held stable until pix_ready=1, then go to IDLE.
- req_ready=0 in every state except IDLE; exactly one request in flight.
- flash_rd_valid is ignored outside WAIT.
- Minimum latency (req accepted → pix_valid) is 3 cycles when flash responds the cycle after flash_rd_req rises.
- Back-to-back: in the cycle pix_valid and pix_ready are both 1, the FSM returns to IDLE. The next request is accepted the following cycle, with no combinational ready path.
- Counter clears on entering ISSUE.

Optional Feature:
- Macro: FONT_WORD_CACHE_EN.
- Defined:
  - A one-entry cache holds the last successfully read word and its wordAddr, plus a valid bit.
  - In IDLE, an accepted request whose wordAddr matches the valid tag skips ISSUE/WAIT and goes directly to RESP with pix from the cached word. pix_valid follows on the next cycle, latency 1.
  - The cache is filled only on a flash_rd_valid capture, never on timeout.
  - The cache is invalidated by reset.
- Undefined: no cache storage; every request takes the ISSUE/WAIT path.

Test Plan:
- Reset then single request, no cache: addressOffsetBits=0x12345, characterIndex=0x41 → bitAddr 0x94345. Expect flash_rd_addr=0x4A1A, bitSel=5. flash_rd_data=0x00000020 returned 1 cycle later → pix=1, pix_err=0, pix_valid 3 cycles after acceptance.
- Same request but flash_rd_data=0xFFFFFFDF → pix=0. Hold pix_ready=0 for 5 cycles → pix_valid and pix stable, req_ready=0 throughout.
- Timeout: never assert flash_rd_valid, TIMEOUT_CYCLES=255 → after 255 WAIT cycles pix_valid=1, pix=0, pix_err=1, flash_rd_req=0. A late flash_rd_valid is ignored.
- Wrap and char masking: addressOffsetBits=0x3FFFFFFF, characterIndex=0x0101 (masked to 0x01) → bitAddr 0x00001FFF, flash_rd_addr=0x0FF, bitSel=31.
- Reset mid-WAIT: assert rst=0 during WAIT → all outputs 0 immediately. After release, req_ready=1 and a stale flash_rd_valid produces no pix_valid.
- FONT_WORD_CACHE_EN: two requests with the same wordAddr 0x4A1A, bitSel 5 then 6 → the second issues no flash_rd_req and gives pix_valid 1 cycle after acceptance, using the cached word bit 6.

Source files
------------

// File: rtl/font_flash_reader.sv
// Glyph pixel fetch: adds the character term to the bit offset, reads the word from font flash, returns one bit.
// Optional one-word cache enabled with `define FONT_WORD_CACHE_EN.
module font_flash_reader #(
  parameter int memFontHeight     = 128,
  parameter int memFontWidth      = 64,
  parameter int charactersPerFont = 256,
  parameter int FLASH_WORD_W      = 32,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [29:0]                         addressOffsetBits,
  input  logic [15:0]                         characterIndex,
  output logic                                flash_rd_req,
  output logic [29-$clog2(FLASH_WORD_W):0]    flash_rd_addr,
  input  logic                                flash_rd_valid,
  input  logic [FLASH_WORD_W-1:0]             flash_rd_data,
  output logic                                pix_valid,
  input  logic                                pix_ready,
  output logic                                pix,
  output logic                                pix_err
);

  localparam int CHAR_W   = $clog2(charactersPerFont);
  localparam int GLYPH_SH = $clog2(memFontHeight) + $clog2(memFontWidth);
  localparam int SEL_W    = $clog2(FLASH_WORD_W);
  localparam int WA_W     = 30 - SEL_W;
  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WA_W-1:0]    wa_p0;
  logic [SEL_W-1:0]   sel_p0;
  logic [29:0]        bit_addr;
  logic [WA_W-1:0]    req_wa;
  logic [SEL_W-1:0]   req_sel;
  logic               accept;
  logic               unused_char_hi;

  function automatic logic [29:0] glyph_bit_addr(input logic [29:0] off,
                                                 input logic [15:0] ch);
    logic [29:0] ch_term;
    ch_term = 30'(ch[CHAR_W-1:0]) << GLYPH_SH;
    return off + ch_term;
  endfunction

  assign bit_addr       = glyph_bit_addr(addressOffsetBits, characterIndex);
  assign req_wa         = bit_addr[29:SEL_W];
  assign req_sel        = bit_addr[SEL_W-1:0];
  assign accept         = (state == IDLE) && req_ready && req_valid;
  assign unused_char_hi = ^characterIndex[15:CHAR_W];

`ifdef FONT_WORD_CACHE_EN
  logic                    cache_vld;
  logic [WA_W-1:0]         cache_tag;
  logic [FLASH_WORD_W-1:0] cache_word;
  logic                    cache_hit;

  assign cache_hit = cache_vld && (cache_tag == req_wa);
`endif

  // p0: request address latch (and cache fill); data only, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      wa_p0  <= req_wa;
      sel_p0 <= req_sel;
    end
`ifdef FONT_WORD_CACHE_EN
    if (state == WAIT && flash_rd_valid) begin
      cache_word <= flash_rd_data;
      cache_tag  <= wa_p0;
    end
`endif
  end

  // control FSM with registered handshake and flash outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      flash_rd_req  <= 1'b0;
      flash_rd_addr <= '0;
      pix_valid     <= 1'b0;
      pix           <= 1'b0;
      pix_err       <= 1'b0;
      cnt           <= '0;
`ifdef FONT_WORD_CACHE_EN
      cache_vld     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            cnt       <= '0;
`ifdef FONT_WORD_CACHE_EN
            if (cache_hit) begin
              pix       <= cache_word[req_sel];
              pix_err   <= 1'b0;
              pix_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= ISSUE;
            end
`else
            state <= ISSUE;
`endif
          end else begin
            req_ready <= 1'b1;
          end
        end
        ISSUE: begin
          flash_rd_req  <= 1'b1;
          flash_rd_addr <= wa_p0;
          cnt           <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          // returned data takes priority over a timeout in the same cycle
          if (flash_rd_valid) begin
            pix          <= flash_rd_data[sel_p0];
            pix_err      <= 1'b0;
            flash_rd_req <= 1'b0;
            pix_valid    <= 1'b1;
            state        <= RESP;
`ifdef FONT_WORD_CACHE_EN
            cache_vld    <= 1'b1;
`endif
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            pix          <= 1'b0;
            pix_err      <= 1'b1;
            flash_rd_req <= 1'b0;
            pix_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
